// File: rtl/garegga_snd_pkg.sv
// Shared definitions for the Garegga sound path: address width default,
// PCM fetch FSM states and ADPCM client indices.
package garegga_snd_pkg;

    localparam int AW_DEFAULT = 20;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetch_state_t;

    localparam logic CLI_A = 1'b0;
    localparam logic CLI_B = 1'b1;

endpackage

// File: rtl/garegga_pcm_line.sv
// One-word PCM line buffer: tag compare and byte select for the client,
// fill port from the SDRAM arbiter, and bank-switch invalidate.
module garegga_pcm_line
    import garegga_snd_pkg::*;
#(
    parameter int AW = AW_DEFAULT
)(
    input  logic          CLK96,
    input  logic          RESET96,
    input  logic          i_inval,
    input  logic          i_cs,
    input  logic [AW-1:0] i_addr,
    output logic          o_hit,
    output logic [7:0]    o_data,
    input  logic          i_wr,
    input  logic          i_wr_valid,
    input  logic [AW-2:0] i_wr_tag,
    input  logic [15:0]   i_wr_word
);

    logic          r_valid;
    logic [AW-2:0] r_tag;
    logic [15:0]   r_word;

    // NOTE: state is updated with <= so every register samples pre-edge values;
    // tag and word are reset too, since one word is cheap and it keeps o_data defined.
    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_word  <= '0;
        end else if (i_wr) begin
            r_valid <= i_wr_valid;
            r_tag   <= i_wr_tag;
            r_word  <= i_wr_word;
        end else if (i_inval) begin
            r_valid <= 1'b0;
        end
    end

    assign o_hit  = i_cs && r_valid && (r_tag == i_addr[AW-1:1]);
    assign o_data = i_addr[0] ? r_word[15:8] : r_word[7:0];

endmodule

// File: rtl/garegga_pcm_fetch.sv
// Two-client PCM ROM front end: per-client word line buffers sharing one
// SDRAM slot through a round-robin miss arbiter.
module garegga_pcm_fetch
    import garegga_snd_pkg::*;
#(
    parameter int AW      = AW_DEFAULT,
    parameter bit RR_INIT = 1'b0
)(
    input  logic          CLK96,
    input  logic          RESET96,
    input  logic          FLUSH,
    input  logic          A_CS,
    input  logic [AW-1:0] A_ADDR,
    output logic [7:0]    A_DATA,
    output logic          A_OK,
    input  logic          B_CS,
    input  logic [AW-1:0] B_ADDR,
    output logic [7:0]    B_DATA,
    output logic          B_OK,
    output logic          SDRAM_CS,
    output logic [AW-2:0] SDRAM_ADDR,
    input  logic [15:0]   SDRAM_DATA,
    input  logic          SDRAM_OK
);

    fetch_state_t  r_state;
    logic          r_grant;
    logic          r_ptr;
    logic          r_discard;
    logic          r_sdram_cs;
    logic [AW-2:0] r_sdram_addr;

    logic w_hit_a, w_hit_b;
    logic w_miss_a, w_miss_b;
    logic w_fill, w_fill_valid;
    logic w_wr_a, w_wr_b;
    logic w_pick;

    assign w_miss_a = A_CS && !w_hit_a;
    assign w_miss_b = B_CS && !w_hit_b;

    // A flush seen at any point of the fetch, including the return cycle, poisons the word.
    assign w_fill       = (r_state == FETCH) && SDRAM_OK;
    assign w_fill_valid = !(r_discard || FLUSH);
    assign w_wr_a       = w_fill && (r_grant == CLI_A);
    assign w_wr_b       = w_fill && (r_grant == CLI_B);

    // NOTE: w_pick gets a default before the ifs so no path leaves it unassigned (no latch).
    always_comb begin
        w_pick = r_ptr;
        if (w_miss_a && !w_miss_b)
            w_pick = CLI_A;
        else if (w_miss_b && !w_miss_a)
            w_pick = CLI_B;
    end

    // The pointer always moves to the client not just served: a toggle on
    // contention, and "the other one" after a lone miss.
    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            r_state      <= IDLE;
            r_grant      <= CLI_A;
            r_ptr        <= RR_INIT;
            r_discard    <= 1'b0;
            r_sdram_cs   <= 1'b0;
            r_sdram_addr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_discard <= 1'b0;
                    if (w_miss_a || w_miss_b) begin
                        r_grant      <= w_pick;
                        r_ptr        <= ~w_pick;
                        r_sdram_addr <= (w_pick == CLI_A) ? A_ADDR[AW-1:1] : B_ADDR[AW-1:1];
                        r_sdram_cs   <= 1'b1;
                        r_state      <= FETCH;
                    end
                end
                FETCH: begin
                    if (FLUSH)
                        r_discard <= 1'b1;
                    if (SDRAM_OK) begin
                        r_sdram_cs <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign SDRAM_CS   = r_sdram_cs;
    assign SDRAM_ADDR = r_sdram_addr;

    garegga_pcm_line #(.AW(AW)) u_line_a (
        .CLK96      (CLK96),
        .RESET96    (RESET96),
        .i_inval    (FLUSH),
        .i_cs       (A_CS),
        .i_addr     (A_ADDR),
        .o_hit      (w_hit_a),
        .o_data     (A_DATA),
        .i_wr       (w_wr_a),
        .i_wr_valid (w_fill_valid),
        .i_wr_tag   (r_sdram_addr),
        .i_wr_word  (SDRAM_DATA)
    );

    garegga_pcm_line #(.AW(AW)) u_line_b (
        .CLK96      (CLK96),
        .RESET96    (RESET96),
        .i_inval    (FLUSH),
        .i_cs       (B_CS),
        .i_addr     (B_ADDR),
        .o_hit      (w_hit_b),
        .o_data     (B_DATA),
        .i_wr       (w_wr_b),
        .i_wr_valid (w_fill_valid),
        .i_wr_tag   (r_sdram_addr),
        .i_wr_word  (SDRAM_DATA)
    );

    assign A_OK = w_hit_a;
    assign B_OK = w_hit_b;

endmodule

// File: tb/tb_garegga_pcm_fetch.sv
// Bench for garegga_pcm_fetch: directed corner sequences, a hit table, and a
// randomized run against a ROM-content model with flush generations.
module tb_garegga_pcm_fetch;
    import garegga_snd_pkg::*;

    localparam int AW   = 20;
    localparam int WAW  = AW - 1;
    localparam int LIVE = 24;
    localparam int SIG_CS = 0, SIG_SDOK = 1, SIG_AOK = 2, SIG_BOK = 3;

    logic           CLK96 = 1'b0;
    logic           RESET96 = 1'b0;
    logic           FLUSH = 1'b0;
    logic           A_CS = 1'b0, B_CS = 1'b0;
    logic [AW-1:0]  A_ADDR = '0, B_ADDR = '0;
    logic [7:0]     A_DATA, B_DATA;
    logic           A_OK, B_OK;
    logic           SDRAM_CS;
    logic [WAW-1:0] SDRAM_ADDR;
    logic [15:0]    SDRAM_DATA = '0;
    logic           SDRAM_OK = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int unsigned gen = 0;

    int          sd_lat = 2;
    bit          sd_rand = 1'b0;
    bit          sd_ovr = 1'b0;
    logic [15:0] sd_ovr_data = '0;
    bit          sd_busy = 1'b0;
    int          sd_cnt = 0;
    logic [15:0] sd_word = '0;

    typedef struct {
        logic          a_cs;
        logic [AW-1:0] a_addr;
        logic          b_cs;
        logic [AW-1:0] b_addr;
        logic          a_ok;
        logic [7:0]    a_data;
        logic          b_ok;
        logic [7:0]    b_data;
    } vec_t;
    vec_t tbl[6];

    always #5 CLK96 = ~CLK96;

    garegga_pcm_fetch #(.AW(AW), .RR_INIT(1'b0)) dut (
        .CLK96      (CLK96),
        .RESET96    (RESET96),
        .FLUSH      (FLUSH),
        .A_CS       (A_CS),
        .A_ADDR     (A_ADDR),
        .A_DATA     (A_DATA),
        .A_OK       (A_OK),
        .B_CS       (B_CS),
        .B_ADDR     (B_ADDR),
        .B_DATA     (B_DATA),
        .B_OK       (B_OK),
        .SDRAM_CS   (SDRAM_CS),
        .SDRAM_ADDR (SDRAM_ADDR),
        .SDRAM_DATA (SDRAM_DATA),
        .SDRAM_OK   (SDRAM_OK)
    );

    // ROM contents; every bank switch (FLUSH) moves to a new generation of data.
    function automatic logic [15:0] mem_word(input logic [WAW-1:0] wa, input int unsigned g);
        logic [15:0] k;
        k = 16'(g * 32'h1F35);
        return wa[15:0] ^ {wa[18:16], 13'd0} ^ k;
    endfunction

    function automatic logic [7:0] sel(input logic [15:0] w, input logic b);
        return b ? w[15:8] : w[7:0];
    endfunction

    always @(posedge CLK96) if (FLUSH) gen <= gen + 1;

    // SDRAM responder: the word is read when the request is first seen.
    always @(negedge CLK96) begin
        if (RESET96 || !SDRAM_CS) begin
            sd_busy  = 1'b0;
            SDRAM_OK = 1'b0;
        end else if (!sd_busy) begin
            sd_busy  = 1'b1;
            sd_cnt   = sd_rand ? int'($urandom_range(1, 4)) : sd_lat;
            sd_word  = sd_ovr ? sd_ovr_data : mem_word(SDRAM_ADDR, gen);
            SDRAM_OK = 1'b0;
        end else if (!SDRAM_OK) begin
            sd_cnt = sd_cnt - 1;
            if (sd_cnt <= 0) begin
                SDRAM_OK   = 1'b1;
                SDRAM_DATA = sd_word;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK96);
        @(negedge CLK96);
        #1;
    endtask

    function automatic logic sig_val(input int which);
        case (which)
            SIG_CS:   return SDRAM_CS;
            SIG_SDOK: return SDRAM_OK;
            SIG_AOK:  return A_OK;
            default:  return B_OK;
        endcase
    endfunction

    task automatic wait_sig(input string name, input int which, input logic val, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sig_val(which) === val) return;
            step();
        end
        if (sig_val(which) !== val) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: timeout after %0d cycles", name, budget);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] fa, fb;
        bit saw_cs, early;
        int a_hold, b_hold, a_stable, b_stable;
        logic [WAW-1:0] a_prev, b_prev;
        logic a_prev_cs, b_prev_cs;

        #1 RESET96 = 1'b1;
        repeat (3) @(negedge CLK96);
        #1;
        check("rst_sdram_cs",   32'(SDRAM_CS),   0);
        check("rst_sdram_addr", 32'(SDRAM_ADDR), 0);
        check("rst_a_ok",       32'(A_OK),       0);
        check("rst_b_ok",       32'(B_OK),       0);
        check("rst_a_data",     32'(A_DATA),     0);
        check("rst_b_data",     32'(B_DATA),     0);
        RESET96 = 1'b0;
        step();

        // Cold miss with a fixed SDRAM word
        sd_ovr = 1'b1; sd_ovr_data = 16'hBEEF; sd_lat = 5;
        A_CS = 1'b1; A_ADDR = 20'h00101;
        #1;
        check("cold_a_ok_pre", 32'(A_OK), 0);
        step();
        check("cold_sdram_cs",   32'(SDRAM_CS),   1);
        check("cold_sdram_addr", 32'(SDRAM_ADDR), 'h00080);
        wait_sig("cold_sdram_ok", SIG_SDOK, 1'b1, 20);
        check("cold_a_ok_with_sdram_ok", 32'(A_OK), 0);
        step();
        check("cold_a_ok",   32'(A_OK),     1);
        check("cold_a_data", 32'(A_DATA),   'hBE);
        check("cold_cs_low", 32'(SDRAM_CS), 0);
        A_ADDR = 20'h00100;
        #1;
        check("hit_a_ok",   32'(A_OK),   1);
        check("hit_a_data", 32'(A_DATA), 'hEF);
        saw_cs = 1'b0;
        repeat (4) begin
            step();
            if (SDRAM_CS) saw_cs = 1'b1;
        end
        check("hit_no_refetch", 32'(saw_cs), 0);
        sd_ovr = 1'b0;

        // Contention straight out of reset
        A_CS = 1'b0;
        RESET96 = 1'b1; step(); RESET96 = 1'b0; step();
        sd_lat = 2;
        A_CS = 1'b1; A_ADDR = 20'h00010;
        B_CS = 1'b1; B_ADDR = 20'h40020;
        step();
        check("cont_first_cs",   32'(SDRAM_CS),   1);
        check("cont_first_addr", 32'(SDRAM_ADDR), 'h00008);
        wait_sig("cont_a_ok", SIG_AOK, 1'b1, 30);
        check("cont_a_data", 32'(A_DATA), 32'(sel(mem_word(19'h00008, gen), 1'b0)));
        check("cont_b_pending", 32'(B_OK), 0);
        wait_sig("cont_second_cs", SIG_CS, 1'b1, 10);
        check("cont_second_addr", 32'(SDRAM_ADDR), 'h20010);
        wait_sig("cont_b_ok", SIG_BOK, 1'b1, 30);
        check("cont_b_data", 32'(B_DATA), 32'(sel(mem_word(19'h20010, gen), 1'b0)));
        A_ADDR = 20'h00031; B_ADDR = 20'h40041;
        step();
        check("cont2_first_addr", 32'(SDRAM_ADDR), 'h00018);
        wait_sig("cont2_b_ok", SIG_BOK, 1'b1, 40);
        check("cont2_a_ok",   32'(A_OK),   1);
        check("cont2_a_data", 32'(A_DATA), 32'(sel(mem_word(19'h00018, gen), 1'b1)));
        check("cont2_b_data", 32'(B_DATA), 32'(sel(mem_word(19'h20020, gen), 1'b1)));

        // Hit table over the two filled lines
        fa = mem_word(19'h00018, gen);
        fb = mem_word(19'h20020, gen);
        tbl[0] = '{1'b1, 20'h00030, 1'b1, 20'h40040, 1'b1, fa[7:0],  1'b1, fb[7:0]};
        tbl[1] = '{1'b1, 20'h00031, 1'b1, 20'h40041, 1'b1, fa[15:8], 1'b1, fb[15:8]};
        tbl[2] = '{1'b0, 20'h00031, 1'b1, 20'h40040, 1'b0, fa[15:8], 1'b1, fb[7:0]};
        tbl[3] = '{1'b1, 20'h00030, 1'b0, 20'h12345, 1'b1, fa[7:0],  1'b0, fb[15:8]};
        tbl[4] = '{1'b0, 20'hFFFFE, 1'b0, 20'h00000, 1'b0, fa[7:0],  1'b0, fb[7:0]};
        tbl[5] = '{1'b1, 20'h00031, 1'b1, 20'h40041, 1'b1, fa[15:8], 1'b1, fb[15:8]};
        for (int i = 0; i < 6; i++) begin
            A_CS = tbl[i].a_cs; A_ADDR = tbl[i].a_addr;
            B_CS = tbl[i].b_cs; B_ADDR = tbl[i].b_addr;
            #1;
            check($sformatf("tbl%0d_a_ok", i),   32'(A_OK),   32'(tbl[i].a_ok));
            check($sformatf("tbl%0d_a_data", i), 32'(A_DATA), 32'(tbl[i].a_data));
            check($sformatf("tbl%0d_b_ok", i),   32'(B_OK),   32'(tbl[i].b_ok));
            check($sformatf("tbl%0d_b_data", i), 32'(B_DATA), 32'(tbl[i].b_data));
            step();
            check($sformatf("tbl%0d_sdram_cs", i), 32'(SDRAM_CS), 0);
        end

        // Client address moves while its fetch is in flight
        B_CS = 1'b0; sd_lat = 4;
        A_CS = 1'b1; A_ADDR = 20'h00200;
        step();
        check("stale_addr1", 32'(SDRAM_ADDR), 'h00100);
        step();
        A_ADDR = 20'h00400;
        wait_sig("stale_first_done", SIG_CS, 1'b0, 20);
        check("stale_a_ok_after_fill", 32'(A_OK), 0);
        wait_sig("stale_second_cs", SIG_CS, 1'b1, 5);
        check("stale_addr2", 32'(SDRAM_ADDR), 'h00200);
        early = 1'b0;
        for (int i = 0; i < 20 && !SDRAM_OK; i++) begin
            if (A_OK) early = 1'b1;
            step();
        end
        if (A_OK) early = 1'b1;
        check("stale_ok_early", 32'(early), 0);
        step();
        check("stale_a_ok",   32'(A_OK),   1);
        check("stale_a_data", 32'(A_DATA), 32'(sel(mem_word(19'h00200, gen), 1'b0)));

        // FLUSH on the same cycle as SDRAM_OK
        sd_lat = 3;
        A_ADDR = 20'h00601;
        step();
        wait_sig("flush_c_sdram_ok", SIG_SDOK, 1'b1, 20);
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        check("flush_c_a_ok", 32'(A_OK), 0);
        wait_sig("flush_c_refetch", SIG_CS, 1'b1, 5);
        check("flush_c_refetch_addr", 32'(SDRAM_ADDR), 'h00300);
        wait_sig("flush_c_a_ok_new", SIG_AOK, 1'b1, 20);
        check("flush_c_a_data", 32'(A_DATA), 32'(sel(mem_word(19'h00300, gen), 1'b1)));

        // FLUSH in the middle of a fetch
        sd_lat = 4;
        A_ADDR = 20'h00800;
        step();
        step();
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        wait_sig("flush_l_done", SIG_CS, 1'b0, 20);
        check("flush_l_a_ok", 32'(A_OK), 0);
        wait_sig("flush_l_refetch", SIG_CS, 1'b1, 5);
        check("flush_l_refetch_addr", 32'(SDRAM_ADDR), 'h00400);
        wait_sig("flush_l_a_ok_new", SIG_AOK, 1'b1, 20);
        check("flush_l_a_data", 32'(A_DATA), 32'(sel(mem_word(19'h00400, gen), 1'b0)));

        // FLUSH while both clients hit
        B_CS = 1'b1; B_ADDR = 20'h40100;
        wait_sig("flush_i_b_ok", SIG_BOK, 1'b1, 30);
        check("flush_i_pre_a_ok", 32'(A_OK), 1);
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        check("flush_i_a_ok", 32'(A_OK), 0);
        check("flush_i_b_ok_drop", 32'(B_OK), 0);

        // Reset in the middle of a fetch
        A_ADDR = 20'h00A00; B_CS = 1'b0; sd_lat = 6;
        step();
        check("rstmid_pre_cs",   32'(SDRAM_CS),   1);
        check("rstmid_pre_addr", 32'(SDRAM_ADDR), 'h00500);
        step();
        RESET96 = 1'b1;
        #1;
        check("rstmid_cs",   32'(SDRAM_CS), 0);
        check("rstmid_a_ok", 32'(A_OK),     0);
        check("rstmid_b_ok", 32'(B_OK),     0);
        step();
        RESET96 = 1'b0;
        step();
        check("rstmid_post_cs",   32'(SDRAM_CS),   1);
        check("rstmid_post_addr", 32'(SDRAM_ADDR), 'h00500);
        wait_sig("rstmid_a_ok_new", SIG_AOK, 1'b1, 20);
        check("rstmid_a_data", 32'(A_DATA), 32'(sel(mem_word(19'h00500, gen), 1'b0)));

        // Idle client B: line filled, then deselected while its address wanders
        A_CS = 1'b0;
        B_CS = 1'b1; B_ADDR = 20'h40100;
        wait_sig("idle_b_fill", SIG_BOK, 1'b1, 30);
        B_CS = 1'b0;
        saw_cs = 1'b0;
        for (int i = 0; i < 16; i++) begin
            B_ADDR = (i % 3 == 2) ? AW'($urandom) : {19'h20080, 1'(i)};
            step();
            check("idle_b_ok", 32'(B_OK), 0);
            if (SDRAM_CS) saw_cs = 1'b1;
        end
        check("idle_no_sdram_cs", 32'(saw_cs), 0);

        // Randomized traffic against the ROM model
        sd_rand = 1'b1;
        a_hold = 0; b_hold = 0; a_stable = 0; b_stable = 0;
        a_prev = '0; b_prev = '0; a_prev_cs = 1'b0; b_prev_cs = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (A_CS && A_OK)
                check("rnd_a_data", 32'(A_DATA), 32'(sel(mem_word(A_ADDR[AW-1:1], gen), A_ADDR[0])));
            if (B_CS && B_OK)
                check("rnd_b_data", 32'(B_DATA), 32'(sel(mem_word(B_ADDR[AW-1:1], gen), B_ADDR[0])));
            if (!A_CS) check("rnd_a_ok_idle", 32'(A_OK), 0);
            if (!B_CS) check("rnd_b_ok_idle", 32'(B_OK), 0);
            if (a_stable == LIVE) check("rnd_a_live", 32'(A_OK), 1);
            if (b_stable == LIVE) check("rnd_b_live", 32'(B_OK), 1);

            FLUSH = ($urandom_range(0, 39) == 0);
            if (a_hold == 0) begin
                a_hold = int'($urandom_range(1, 40));
                A_CS   = ($urandom_range(0, 7) != 0);
                A_ADDR = {19'(32'h00100 + $urandom_range(0, 3)), 1'($urandom)};
            end else a_hold--;
            if (b_hold == 0) begin
                b_hold = int'($urandom_range(1, 40));
                B_CS   = ($urandom_range(0, 7) != 0);
                B_ADDR = {19'(32'h20000 + $urandom_range(0, 3)), 1'($urandom)};
            end else b_hold--;

            if (A_CS && a_prev_cs && A_ADDR[AW-1:1] == a_prev && !FLUSH) a_stable++;
            else a_stable = 0;
            if (B_CS && b_prev_cs && B_ADDR[AW-1:1] == b_prev && !FLUSH) b_stable++;
            else b_stable = 0;
            a_prev = A_ADDR[AW-1:1]; a_prev_cs = A_CS;
            b_prev = B_ADDR[AW-1:1]; b_prev_cs = B_CS;
            step();
        end
        FLUSH = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
